keyboard_event_ctrl: RTL
========================

KEYBOARD_EVENT_CTRL -- requirements
Module: keyboard_event_ctrl

Interface
REQ-001 SHALL have parameter N_KEYS, default 16, meaning number of key inputs (2..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of 2, 2..32).
REQ-003 SHALL have localparam CW = clog2(N_KEYS), the key-code width.
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port key_pulse  in  N_KEYS  one-cycle press pulses, one bit per key.
REQ-007 SHALL have port clr_valid  in  1  qualifies clr_mask.
REQ-008 SHALL have port clr_mask  in  N_KEYS  write-1-to-clear mask for key_reg.
REQ-009 SHALL have port irq_mask  in  N_KEYS  per-key interrupt enable.
REQ-010 SHALL have port ovf_clr  in  1  clears overflow.
REQ-011 SHALL have port pop  in  1  FIFO read strobe.
REQ-012 SHALL have port key_reg  out  N_KEYS  sticky pressed flags.
REQ-013 SHALL have port fifo_data  out  CW  head key code, first-word fall-through.
REQ-014 SHALL have port fifo_empty, fifo_full  out  1 each.
REQ-015 SHALL have port fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
REQ-016 SHALL have port overflow  out  1  sticky lost-event flag.
REQ-017 SHALL have port irq  out  1  level interrupt.

Function
REQ-018 SHALL set key_reg[i] at the edge where key_pulse[i]=1; key_reg bit visible one cycle after the pulse.
REQ-019 SHALL clear key_reg[i] synchronously when clr_valid=1 and clr_mask[i]=1; a set on the same edge SHALL win (bit stays 1).
REQ-020 SHALL hold a pend[N_KEYS] register: bit set by key_pulse, cleared when its code is pushed.
REQ-021 SHALL push at most one code per cycle: the lowest-index set pend bit, when pend != 0 and (!fifo_full or pop).
REQ-022 SHALL push codes present in pend at the start of the cycle; a pulse arriving on that cycle enters pend and is pushed no earlier than the next edge (pulse at t -> fifo_empty low after edge t+2 at the earliest).
REQ-023 SHALL retain pend bits while the FIFO is full; no code is dropped due to a full FIFO.
REQ-024 SHALL set overflow when key_pulse[i]=1 while pend[i]=1 and pend[i] is not pushed on that edge (coalesced event); overflow set wins over ovf_clr.
REQ-025 SHALL ignore pop when fifo_empty; simultaneous push and pop when full SHALL keep fifo_count unchanged.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-027 SHALL drive irq = |(key_reg & irq_mask), from registered state only (no combinational path from key_pulse).
REQ-028 SHALL drive fifo_data = 0 when fifo_empty.

Reset
REQ-029 SHALL on rstn low clear key_reg, pend, overflow, and FIFO pointers/count, asynchronously.
REQ-030 SHALL output after reset: key_reg=0, fifo_data=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, irq=0.
REQ-031 SHALL discard all pending and queued events when reset asserts mid-operation.

Configuration
REQ-032 SHALL honour macro KEYBOARD_FIFO_EN: when defined, pend, FIFO, and overflow are built as above.
REQ-033 SHALL, without KEYBOARD_FIFO_EN, omit pend/FIFO logic, tie fifo_data=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, and ignore pop/ovf_clr; key_reg and irq remain unchanged.

Structure
REQ-034 SHALL place default N_KEYS, FIFO_DEPTH, and the clog2 width function in shared package kbd_pkg.
REQ-035 SHALL implement the FIFO as sub-module kbd_code_fifo (parameters WIDTH, DEPTH; push/pop/data/empty/full/count).

Verification
REQ-036 SHALL verify: pulse key 5 -> key_reg=0x0020 next cycle; clr_valid with mask 0x0020 -> key_reg=0.
REQ-037 SHALL verify: key_pulse=0x8001 in one cycle -> FIFO pops 0 then 15; fifo_count peaks at 2.
REQ-038 SHALL verify: 9 distinct keys with FIFO_DEPTH=8 and no pop -> fifo_full=1, one pend bit held, overflow=0; a single pop -> 9th code pushed next edge.
REQ-039 SHALL verify: key 3 pulsed twice while FIFO full -> overflow=1; ovf_clr -> overflow=0.
REQ-040 SHALL verify: irq_mask=0x0004, pulse key 2 -> irq=1; clear on the same edge as a new pulse of key 2 -> key_reg[2] and irq stay 1.
REQ-041 SHALL verify: rstn low with 4 queued codes -> fifo_empty=1, key_reg=0, irq=0 immediately, without a clock edge.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared defaults and helpers for the keyboard event controller.
// Holds key/FIFO size defaults and the width function.
package kbd_pkg;

  localparam int N_KEYS_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  // Ceiling log2, minimum 1 so single-bit codes still get a wire.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/kbd_code_fifo.sv
// Small synchronous FIFO of key codes, first-word fall-through.
// Pop on empty is ignored; push on full only lands with a pop.
module kbd_code_fifo
  import kbd_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  DEPTH = 8,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/keyboard_event_ctrl.sv
// Sticky key flags, interrupt, and optional ordered event queue.
// Event queue is built only when KEYBOARD_FIFO_EN is defined.
module keyboard_event_ctrl
  import kbd_pkg::*;
#(
  parameter int  N_KEYS     = N_KEYS_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int CW         = clog2(N_KEYS),
  localparam int NW         = clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_KEYS-1:0] key_pulse,
  input  logic              clr_valid,
  input  logic [N_KEYS-1:0] clr_mask,
  input  logic [N_KEYS-1:0] irq_mask,
  input  logic              ovf_clr,
  input  logic              pop,
  output logic [N_KEYS-1:0] key_reg,
  output logic [CW-1:0]     fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [NW-1:0]     fifo_count,
  output logic              overflow,
  output logic              irq
);

  logic [N_KEYS-1:0] clr_bits;

  assign clr_bits = clr_valid ? clr_mask : '0;
  assign irq      = |(key_reg & irq_mask);

  // Sticky flags: a new press beats a clear on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) key_reg <= '0;
    else       key_reg <= (key_reg & ~clr_bits) | key_pulse;
  end

`ifdef KEYBOARD_FIFO_EN

  logic [N_KEYS-1:0] pend;
  logic [N_KEYS-1:0] low_bit;
  logic [N_KEYS-1:0] push_oh;
  logic [CW-1:0]     code;
  logic              push_en;
  logic              ovf_set;

  assign low_bit = pend & (~pend + 1'b1);
  assign push_en = (|pend) && (!fifo_full || pop);
  assign push_oh = push_en ? low_bit : '0;
  assign ovf_set = |(key_pulse & pend & ~push_oh);

  // Encode the lowest pending key as the code to queue.
  always_comb begin
    code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend[i]) code = CW'(i);
    end
  end

  // Pending set by presses, released as each code enters the queue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pend <= '0;
    else       pend <= (pend & ~push_oh) | key_pulse;
  end

  // Lost-event flag: a press folded into a still-pending one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  kbd_code_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_en),
    .pop   (pop),
    .wdata (code),
    .rdata (fifo_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

`else

  logic unused_in;

  assign unused_in  = ^{pop, ovf_clr};
  assign fifo_data  = '0;
  assign fifo_empty = 1'b1;
  assign fifo_full  = 1'b0;
  assign fifo_count = '0;
  assign overflow   = 1'b0;

`endif

endmodule
